// File: rtl/jtag_tap_pkg.sv
// Shared types for the multi-channel JTAG TAP: FSM state encoding, fixed opcodes, DR select.
// Pure declarations, no logic.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TestLogicReset = 4'd0,
    RunTestIdle    = 4'd1,
    SelectDrScan   = 4'd2,
    CaptureDr      = 4'd3,
    ShiftDr        = 4'd4,
    Exit1Dr        = 4'd5,
    PauseDr        = 4'd6,
    Exit2Dr        = 4'd7,
    UpdateDr       = 4'd8,
    SelectIrScan   = 4'd9,
    CaptureIr      = 4'd10,
    ShiftIr        = 4'd11,
    Exit1Ir        = 4'd12,
    PauseIr        = 4'd13,
    Exit2Ir        = 4'd14,
    UpdateIr       = 4'd15
  } tap_state_e;

  // The all-ones BYPASS opcode depends on IR width and is built in the top.
  localparam int unsigned IrIdcode  = 1;
  localparam int unsigned IrBypass0 = 0;

  typedef enum logic [1:0] {
    SelBypass  = 2'd0,
    SelIdcode  = 2'd1,
    SelChannel = 2'd2
  } dr_sel_e;

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP state machine with capture/shift/update decode; decode is combinational from state.
// Advances one state per rising tck_i; no backpressure.
module jtag_tap_fsm
  import jtag_tap_pkg::*;
(
  input  logic       tck_i,
  input  logic       trst_ni,
  input  logic       tms_i,
  output logic [3:0] state,
  output logic       tlr,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir
);

  tap_state_e state_q, state_d;

  always_ff @(posedge tck_i) begin
    if (!trst_ni) begin
      state_q <= TestLogicReset;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  always_comb begin
    state      = state_q;
    tlr        = (state_q == TestLogicReset);
    capture_dr = (state_q == CaptureDr);
    shift_dr   = (state_q == ShiftDr);
    update_dr  = (state_q == UpdateDr);
    capture_ir = (state_q == CaptureIr);
    shift_ir   = (state_q == ShiftIr);
    update_ir  = (state_q == UpdateIr);
  end

endmodule

// File: rtl/jtag_tap_multi.sv
// JTAG TAP with IDCODE, BYPASS and NumChannels user DR channels selected by opcode; TDO registered on falling tck_i.
// TDO valid half a cycle after entering a shift state; bypass adds one tck of delay; no backpressure.
module jtag_tap_multi
  import jtag_tap_pkg::*;
#(
  parameter int unsigned                              IrLength       = 5,
  parameter logic [31:0]                              IdcodeValue    = 32'h00000001,
  parameter logic [IrLength-1:0]                      IrCaptureValue = IrLength'(5'b00101),
  parameter int unsigned                              NumChannels    = 2,
  parameter logic [NumChannels-1:0][IrLength-1:0]     ChannelOpcodes = {5'h11, 5'h10}
) (
  input  logic                   tck_i,
  input  logic                   trst_ni,
  input  logic                   tms_i,
  input  logic                   td_i,
  output logic                   td_o,
  output logic                   tdo_oe_o,
  output logic [3:0]             tap_state_o,
  output logic                   tlr_o,
  output logic [IrLength-1:0]    ir_o,
  output logic                   capture_o,
  output logic                   shift_o,
  output logic                   update_o,
  output logic                   tdi_o,
  output logic [NumChannels-1:0] ch_select_o,
  input  logic [NumChannels-1:0] ch_tdo_i
);

  localparam logic [IrLength-1:0] IrIdcodeOp  = IrLength'(IrIdcode);
  localparam logic [IrLength-1:0] IrBypass0Op = IrLength'(IrBypass0);
  localparam logic [IrLength-1:0] IrBypass1Op = '1;

  logic [IrLength-1:0]    ir_q, ir_shift_q;
  logic [31:0]            idcode_q;
  logic                   bypass_q;
  logic                   tlr, capture_dr, shift_dr, update_dr;
  logic                   capture_ir, shift_ir, update_ir;
  dr_sel_e                dr_sel;
  logic [NumChannels-1:0] ch_sel;
  logic                   tdo_mux;

  jtag_tap_fsm u_fsm (
    .tck_i      (tck_i),
    .trst_ni    (trst_ni),
    .tms_i      (tms_i),
    .state      (tap_state_o),
    .tlr        (tlr),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir)
  );

  assign tlr_o       = tlr;
  assign capture_o   = capture_dr;
  assign shift_o     = shift_dr;
  assign update_o    = update_dr;
  assign ir_o        = ir_q;
  assign tdi_o       = td_i;
  assign ch_select_o = ch_sel;

  // Reserved opcodes win; among channels sharing an opcode the lowest index wins.
  always_comb begin
    ch_sel = '0;
    dr_sel = SelBypass;
    if (ir_q == IrIdcodeOp) begin
      dr_sel = SelIdcode;
    end else if (ir_q != IrBypass0Op && ir_q != IrBypass1Op) begin
      for (int i = 0; i < NumChannels; i++) begin
        if (dr_sel == SelBypass && ChannelOpcodes[i] == ir_q) begin
          ch_sel[i] = 1'b1;
          dr_sel    = SelChannel;
        end
      end
    end
  end

  always_ff @(posedge tck_i) begin
    if (!trst_ni) begin
      ir_q       <= IrIdcodeOp;
      ir_shift_q <= '0;
    end else begin
      if (capture_ir) begin
        ir_shift_q <= IrCaptureValue;
      end else if (shift_ir) begin
        ir_shift_q <= {td_i, ir_shift_q[IrLength-1:1]};
      end
      if (tlr) begin
        ir_q <= IrIdcodeOp;
      end else if (update_ir) begin
        ir_q <= ir_shift_q;
      end
    end
  end

  always_ff @(posedge tck_i) begin
    if (!trst_ni) begin
      idcode_q <= IdcodeValue;
      bypass_q <= 1'b0;
    end else begin
      if (dr_sel == SelIdcode) begin
        if (capture_dr) begin
          idcode_q <= IdcodeValue;
        end else if (shift_dr) begin
          idcode_q <= {td_i, idcode_q[31:1]};
        end
      end
      if (dr_sel == SelBypass) begin
        if (capture_dr) begin
          bypass_q <= 1'b0;
        end else if (shift_dr) begin
          bypass_q <= td_i;
        end
      end
    end
  end

  always_comb begin
    tdo_mux = bypass_q;
    if (shift_ir) begin
      tdo_mux = ir_shift_q[0];
    end else if (dr_sel == SelIdcode) begin
      tdo_mux = idcode_q[0];
    end else if (dr_sel == SelChannel) begin
      tdo_mux = |(ch_sel & ch_tdo_i);
    end
  end

  // Falling-edge launch gives the board half a cycle of setup to the next rising edge.
  always_ff @(negedge tck_i) begin
    if (!trst_ni) begin
      td_o     <= 1'b0;
      tdo_oe_o <= 1'b0;
    end else begin
      td_o     <= tdo_mux;
      tdo_oe_o <= shift_ir | shift_dr;
    end
  end

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Bench for jtag_tap_multi: directed scenarios plus random TMS/TDI traffic against a behavioural model.
module tb_jtag_tap_multi;

  logic       tck = 1'b0;
  logic       trst_ni = 1'b0;
  logic       tms_i = 1'b1;
  logic       td_i = 1'b0;
  logic [1:0] ch_tdo_i = 2'b00;
  logic       td_o, tdo_oe_o, tlr_o, capture_o, shift_o, update_o, tdi_o;
  logic [3:0] tap_state_o;
  logic [4:0] ir_o;
  logic [1:0] ch_select_o;

  int checks = 0;
  int errors = 0;

  jtag_tap_multi dut (
    .tck_i       (tck),
    .trst_ni     (trst_ni),
    .tms_i       (tms_i),
    .td_i        (td_i),
    .td_o        (td_o),
    .tdo_oe_o    (tdo_oe_o),
    .tap_state_o (tap_state_o),
    .tlr_o       (tlr_o),
    .ir_o        (ir_o),
    .capture_o   (capture_o),
    .shift_o     (shift_o),
    .update_o    (update_o),
    .tdi_o       (tdi_o),
    .ch_select_o (ch_select_o),
    .ch_tdo_i    (ch_tdo_i)
  );

  always #5 tck = ~tck;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: TAP graph as next-state tables (index = state number), registers as plain values.
  localparam logic [31:0] IDV  = 32'h00000001;
  localparam logic [4:0]  CAPV = 5'b00101;
  int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
  int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
  logic [4:0] opc [2] = '{5'h10, 5'h11};

  int         m_state = 0;
  logic [4:0] m_ir = 5'h01;
  logic [4:0] m_irs = 5'h00;
  logic [31:0] m_id = IDV;
  logic       m_byp = 1'b0;
  logic       m_tdo = 1'b0;
  logic       m_oe = 1'b0;

  // -2 = IDCODE, -1 = BYPASS, otherwise channel index
  function automatic int model_sel(input logic [4:0] ir);
    if (ir == 5'h00 || ir == 5'h1f) return -1;
    if (ir == 5'h01) return -2;
    for (int i = 0; i < 2; i++) if (opc[i] == ir) return i;
    return -1;
  endfunction

  task automatic model_rise();
    int sel;
    if (!trst_ni) begin
      m_state = 0; m_ir = 5'h01; m_irs = 5'h00; m_id = IDV; m_byp = 1'b0;
    end else begin
      sel = model_sel(m_ir);
      if (m_state == 10) m_irs = CAPV;
      if (m_state == 11) m_irs = (m_irs >> 1) | (5'(td_i) << 4);
      if (m_state == 15) m_ir = m_irs;
      if (m_state == 0)  m_ir = 5'h01;
      if (m_state == 3 && sel == -2) m_id = IDV;
      if (m_state == 3 && sel == -1) m_byp = 1'b0;
      if (m_state == 4 && sel == -2) m_id = (m_id >> 1) | (32'(td_i) << 31);
      if (m_state == 4 && sel == -1) m_byp = td_i;
      m_state = tms_i ? nxt1[m_state] : nxt0[m_state];
    end
  endtask

  task automatic model_fall();
    int sel;
    if (!trst_ni) begin
      m_tdo = 1'b0; m_oe = 1'b0;
    end else begin
      sel  = model_sel(m_ir);
      m_oe = (m_state == 4 || m_state == 11);
      if (m_state == 11)  m_tdo = m_irs[0];
      else if (sel == -2) m_tdo = m_id[0];
      else if (sel >= 0)  m_tdo = ch_tdo_i[sel];
      else                m_tdo = m_byp;
    end
  endtask

  function automatic logic [17:0] model_vec();
    int sel;
    logic [1:0] cs;
    sel = model_sel(m_ir);
    cs  = (sel >= 0) ? 2'(1 << sel) : 2'b00;
    return {4'(m_state), m_ir, m_tdo, m_oe, cs, m_state == 3, m_state == 4,
            m_state == 8, m_state == 0, td_i};
  endfunction

  wire [17:0] obs_vec = {tap_state_o, ir_o, td_o, tdo_oe_o, ch_select_o,
                         capture_o, shift_o, update_o, tlr_o, tdi_o};

  task automatic tick(input logic tms, input logic tdi);
    tms_i = tms;
    td_i  = tdi;
    @(posedge tck);
    model_rise();
    @(negedge tck);
    model_fall();
    #1;
  endtask

  // From RunTestIdle: full IR scan, returns the captured shift-out, ends in RunTestIdle.
  task automatic scan_ir(input logic [4:0] op, output logic [4:0] cap);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 5; i++) begin
      cap[i] = td_o;
      tick(i == 4, op[i]);
    end
    tick(1, 0); tick(0, 0);
  endtask

  task automatic goto_shift_dr();
    tick(1, 0); tick(0, 0); tick(0, 0);
  endtask

  task automatic exit_dr();
    tick(1, 0); tick(1, 0); tick(0, 0);
  endtask

  task automatic test_reset();
    trst_ni = 1'b0;
    tick(0, 0); tick(1, 0);
    checks++; if (tap_state_o !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", tap_state_o); end
    checks++; if (ir_o !== 5'h01) begin errors++; $display("FAIL reset_ir got %h exp 01", ir_o); end
    checks++; if (td_o !== 1'b0 || tdo_oe_o !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b%b exp 00", td_o, tdo_oe_o); end
    checks++; if (ch_select_o !== 2'b00 || tlr_o !== 1'b1) begin errors++; $display("FAIL reset_sel got %b tlr %b exp 00 1", ch_select_o, tlr_o); end
    trst_ni = 1'b1;
    tick(1, 0);
  endtask

  task automatic test_idcode();
    logic [31:0] got;
    logic        oe_ok;
    oe_ok = 1'b1;
    tick(0, 0); tick(1, 0); tick(0, 0);
    checks++; if (capture_o !== 1'b1 || tdo_oe_o !== 1'b0) begin errors++; $display("FAIL idcode_capture got cap %b oe %b exp 1 0", capture_o, tdo_oe_o); end
    tick(0, 0);
    for (int i = 0; i < 32; i++) begin
      got[i] = td_o;
      if (tdo_oe_o !== 1'b1) oe_ok = 1'b0;
      tick(i == 31, 1'(i));
    end
    checks++; if (got !== 32'h00000001) begin errors++; $display("FAIL idcode_value got %h exp 00000001", got); end
    checks++; if (!oe_ok) begin errors++; $display("FAIL idcode_oe_during_shift got low exp high"); end
    checks++; if (tdo_oe_o !== 1'b0) begin errors++; $display("FAIL idcode_oe_after got %b exp 0", tdo_oe_o); end
    tick(1, 0); tick(0, 0);
  endtask

  task automatic test_ir_channel();
    logic [4:0] cap;
    scan_ir(5'h11, cap);
    checks++; if (cap !== 5'b00101) begin errors++; $display("FAIL ir_capture got %b exp 00101", cap); end
    checks++; if (ir_o !== 5'h11 || ch_select_o !== 2'b10) begin errors++; $display("FAIL ir_update got %h sel %b exp 11 10", ir_o, ch_select_o); end
    ch_tdo_i = 2'b10;
    goto_shift_dr();
    checks++; if (td_o !== 1'b1 || shift_o !== 1'b1) begin errors++; $display("FAIL ch1_tdo_hi got %b shift %b exp 1 1", td_o, shift_o); end
    ch_tdo_i = 2'b01;
    tick(0, 0);
    checks++; if (td_o !== 1'b0) begin errors++; $display("FAIL ch1_tdo_lo got %b exp 0", td_o); end
    tick(1, 0); tick(1, 0);
    checks++; if (update_o !== 1'b1) begin errors++; $display("FAIL ch1_update got %b exp 1", update_o); end
    tick(0, 0);
  endtask

  task automatic test_bypass();
    logic [4:0] ops [2] = '{5'h07, 5'h1f};
    logic [4:0] cap;
    logic [3:0] pat, got;
    pat = 4'b1101;
    for (int k = 0; k < 2; k++) begin
      scan_ir(ops[k], cap);
      checks++; if (ir_o !== ops[k] || ch_select_o !== 2'b00) begin errors++; $display("FAIL bypass_sel op %h got ir %h sel %b exp 00", ops[k], ir_o, ch_select_o); end
      goto_shift_dr();
      for (int i = 0; i < 4; i++) begin
        got[i] = td_o;
        tick(0, pat[i]);
      end
      checks++; if (got !== 4'b1010) begin errors++; $display("FAIL bypass_delay op %h got %b exp 1010", ops[k], got); end
      exit_dr();
    end
  endtask

  task automatic test_five_tms();
    logic [4:0] cap;
    int upd;
    upd = 0;
    scan_ir(5'h10, cap);
    checks++; if (ch_select_o !== 2'b01) begin errors++; $display("FAIL ch0_select got %b exp 01", ch_select_o); end
    goto_shift_dr();
    for (int i = 0; i < 5; i++) begin
      tick(1, 0);
      if (update_o === 1'b1) upd++;
    end
    checks++; if (tap_state_o !== 4'd0) begin errors++; $display("FAIL five_tms_state got %0d exp 0", tap_state_o); end
    // Exit1Dr -> UpdateDr lies on the five-ones path, so exactly one pulse is seen.
    checks++; if (upd != 1) begin errors++; $display("FAIL five_tms_updates got %0d exp 1", upd); end
    tick(1, 0);
    checks++; if (ir_o !== 5'h01 || ch_select_o !== 2'b00) begin errors++; $display("FAIL five_tms_ir got %h exp 01", ir_o); end
  endtask

  task automatic test_trst_midscan();
    logic [4:0] cap;
    tick(0, 0);
    scan_ir(5'h11, cap);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    tick(0, 1); tick(0, 1);
    checks++; if (tap_state_o !== 4'd11 || tdo_oe_o !== 1'b1) begin errors++; $display("FAIL midscan_pre got %0d oe %b exp 11 1", tap_state_o, tdo_oe_o); end
    trst_ni = 1'b0;
    tick(0, 1);
    checks++; if (tap_state_o !== 4'd0 || ir_o !== 5'h01) begin errors++; $display("FAIL midscan_reset got %0d ir %h exp 0 01", tap_state_o, ir_o); end
    checks++; if (td_o !== 1'b0 || tdo_oe_o !== 1'b0 || update_o !== 1'b0) begin errors++; $display("FAIL midscan_outputs got %b%b%b exp 000", td_o, tdo_oe_o, update_o); end
    trst_ni = 1'b1;
    tick(1, 0);
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 4000; c++) begin
      trst_ni  = ($urandom_range(0, 399) != 0);
      ch_tdo_i = 2'($urandom);
      tick($urandom_range(0, 9) < 3, 1'($urandom));
      checks++;
      if (obs_vec !== model_vec()) begin
        errors++;
        $display("FAIL random_cycle %0d got %h exp %h", c, obs_vec, model_vec());
      end
    end
    trst_ni = 1'b1;
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_ir_channel();
    test_bypass();
    test_five_tms();
    test_trst_midscan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
